// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, arbiter state encoding and nibble helpers.
// Pixel nibble 0 sits in bits [31:28] of its word.
package fb_pkg;

  localparam int H_RES        = 640;
  localparam int V_RES        = 480;
  localparam int PIX_PER_WORD = 8;
  localparam int FB_WORDS     = H_RES * V_RES / PIX_PER_WORD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_FILL
  } state_e;

  function automatic logic [3:0] nib_get(input logic [31:0] word, input logic [2:0] idx);
    logic [4:0] lsb;
    lsb = {3'd7 - idx, 2'b00};
    return word[lsb +: 4];
  endfunction

  function automatic logic [31:0] nib_set(input logic [31:0] word, input logic [2:0] idx,
                                          input logic [3:0] val);
    logic [31:0] res;
    logic [4:0]  lsb;
    lsb          = {3'd7 - idx, 2'b00};
    res          = word;
    res[lsb +: 4] = val;
    return res;
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Maps (x, y) to framebuffer byte address, nibble slot and visibility.
// Purely combinational, zero latency, no backpressure.
module fb_addr_calc
  import fb_pkg::*;
(
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  output logic [31:0] byte_addr_o,
  output logic [2:0]  nib_o,
  output logic        in_range_o
);

  logic [18:0] pix;

  assign pix         = 19'(x_i) + 19'(H_RES) * 19'(y_i);
  assign byte_addr_o = {14'd0, pix[18:3], 2'b00};
  assign nib_o       = pix[2:0];
  assign in_range_o  = (x_i < 10'(H_RES)) && (y_i < 10'(V_RES));

endmodule

// File: rtl/fb_access_arbiter.sv
// Shares one BRAM port: display reads (top priority), nibble RMW pixel writes, frame fill.
// Display pixel 1 cycle after disp_en; uncontended write takes 4 cycles; display cycles stall writes/fill.
module fb_access_arbiter
  import fb_pkg::*;
(
  input  logic        pixelClk,
  input  logic        reset,
  input  logic        disp_en,
  input  logic [9:0]  disp_x,
  input  logic [9:0]  disp_y,
  output logic [3:0]  disp_pixel,
  output logic        disp_valid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [3:0]  wr_color,
  input  logic        fill_start,
  input  logic [3:0]  fill_color,
  output logic        fill_busy,
  output logic [31:0] bram_addr,
  output logic        bram_en,
  output logic [3:0]  bram_we,
  output logic [31:0] bram_din,
  input  logic [31:0] bram_dout
);

  logic [31:0] disp_addr, wr_calc_addr;
  logic [2:0]  disp_nib, wr_calc_nib;
  logic        disp_in_range, wr_in_range;

  fb_addr_calc u_disp_calc (
    .x_i        (disp_x),
    .y_i        (disp_y),
    .byte_addr_o(disp_addr),
    .nib_o      (disp_nib),
    .in_range_o (disp_in_range)
  );

  fb_addr_calc u_wr_calc (
    .x_i        (wr_x),
    .y_i        (wr_y),
    .byte_addr_o(wr_calc_addr),
    .nib_o      (wr_calc_nib),
    .in_range_o (wr_in_range)
  );

  state_e      state_q, state_d;
  logic [15:0] fill_cnt_q, fill_cnt_d;
  logic [3:0]  fill_color_q, fill_color_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [2:0]  wr_nib_q, wr_nib_d;
  logic [3:0]  wr_color_q, wr_color_d;
  logic [31:0] merge_q, merge_d;
  logic        disp_valid_q;
  logic [2:0]  disp_nib_q;

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_color_d = fill_color_q;
    wr_addr_d    = wr_addr_q;
    wr_nib_d     = wr_nib_q;
    wr_color_d   = wr_color_q;
    merge_d      = merge_q;
    bram_en      = 1'b0;
    bram_we      = 4'h0;
    bram_addr    = 32'h0;
    bram_din     = 32'h0;
    wr_ready     = 1'b0;

    if (disp_en) begin
      bram_en   = 1'b1;
      bram_addr = disp_addr;
    end

    case (state_q)
      ST_IDLE: begin
        wr_ready = !fill_start;
        if (fill_start) begin
          fill_color_d = fill_color;
          fill_cnt_d   = 16'd0;
          state_d      = ST_FILL;
        end else if (wr_valid) begin
          wr_addr_d  = wr_calc_addr;
          wr_nib_d   = wr_calc_nib;
          wr_color_d = wr_color;
          if (wr_in_range) state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (!disp_en) begin
          bram_en   = 1'b1;
          bram_addr = wr_addr_q;
          state_d   = ST_CAP;
        end
      end
      ST_CAP: begin
        // Read data from the RD cycle is on bram_dout now, even if display took the port.
        merge_d = nib_set(bram_dout, wr_nib_q, wr_color_q);
        state_d = ST_WR;
      end
      ST_WR: begin
        if (!disp_en) begin
          bram_en   = 1'b1;
          bram_we   = 4'hF;
          bram_addr = wr_addr_q;
          bram_din  = merge_q;
          state_d   = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (!disp_en) begin
          bram_en   = 1'b1;
          bram_we   = 4'hF;
          bram_addr = {14'd0, fill_cnt_q, 2'b00};
          bram_din  = {8{fill_color_q}};
          if (fill_cnt_q == 16'(FB_WORDS - 1)) state_d = ST_IDLE;
          else fill_cnt_d = fill_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset takes the port away immediately so an aborted fill writes nothing more.
    if (reset) begin
      bram_en  = 1'b0;
      bram_we  = 4'h0;
      wr_ready = 1'b0;
    end
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      fill_cnt_q   <= 16'd0;
      fill_color_q <= 4'h0;
      wr_addr_q    <= 32'h0;
      wr_nib_q     <= 3'd0;
      wr_color_q   <= 4'h0;
      merge_q      <= 32'h0;
      disp_valid_q <= 1'b0;
      disp_nib_q   <= 3'd0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_color_q <= fill_color_d;
      wr_addr_q    <= wr_addr_d;
      wr_nib_q     <= wr_nib_d;
      wr_color_q   <= wr_color_d;
      merge_q      <= merge_d;
      disp_valid_q <= disp_en;
      disp_nib_q   <= disp_nib;
    end
  end

  assign disp_valid = disp_valid_q && !reset;
  assign disp_pixel = disp_valid_q ? nib_get(bram_dout, disp_nib_q) : 4'h0;
  assign fill_busy  = (state_q == ST_FILL) && !reset;

  disp_coord_ok: assert property (@(posedge pixelClk) disable iff (reset) disp_en |-> disp_in_range);

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Shares the single 32-bit framebuffer BRAM port between three users:
  - display scan-out reads, which have absolute priority;
  - a pixel-write requester, served by nibble read-modify-write;
  - a whole-frame fill engine.
- Sits in the pixel clock domain, between the VGA timing generator/colour decode and the MicroBlaze BRAM port.
- Framebuffer format is 4-bit pixels, 8 per word; pixel index p = x + H_RES*y; pixel p%8==0 occupies bits [31:28].

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines.
- FB_WORDS, H_RES*V_RES/8 (38400), framebuffer words.

Ports:
- pixelClk  in  1  pixel clock; only clock.
- reset  in  1  synchronous, active-high reset.
- disp_en  in  1  display read request this cycle (hVis & vVis).
- disp_x  in  10  display x coordinate.
- disp_y  in  10  display y coordinate.
- disp_pixel  out  4  display pixel colour index, 1 cycle after disp_en.
- disp_valid  out  1  disp_en delayed 1 cycle.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  write accepted when wr_valid & wr_ready.
- wr_x  in  10  write x coordinate.
- wr_y  in  10  write y coordinate.
- wr_color  in  4  colour index to write.
- fill_start  in  1  1-cycle pulse: fill the whole frame.
- fill_color  in  4  fill colour index.
- fill_busy  out  1  fill in progress.
- bram_addr  out  32  byte address = {word_index, 2'b00}.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  byte write enables.
- bram_din  out  32  write data.
- bram_dout  in  32  read data; 1-cycle latency.

Behaviour:
- Clock and reset: one clock, pixelClk. Reset is synchronous and active-high. While reset=1:
  - state=IDLE, fill counter=0;
  - wr_ready=0, fill_busy=0, disp_valid=0, bram_en=0, bram_we=0.
- Port priority (combinational decode of registered state + disp_en), in order:
  - disp_en=1: bram_en=1, bram_we=0, bram_addr=display word address. Any pending write or fill step stalls and holds its state.
  - Otherwise, the current state's access (below).
  - Otherwise, bram_en=0.
- Display path:
  - Register disp_en→disp_valid and nibble select (p%8).
  - disp_pixel = selected nibble of bram_dout when disp_valid=1, else 0.
- States: IDLE, RD, CAP, WR, FILL.
- IDLE:
  - wr_ready=1 unless fill_start=1 this cycle.
  - fill_start=1 → latch fill_color, counter←0, go to FILL. Fill wins over a simultaneous wr_valid, which is not accepted.
  - Else, on accept, latch x/y/colour:
    - in range (x<H_RES and y<V_RES) → RD;
    - out of range → drop silently, stay in IDLE (ready again next cycle).
- RD: issue read of the target word when disp_en=0, then go to CAP. If disp_en=1, wait in RD.
- CAP:
  - Capture bram_dout into the merge register unconditionally. The read was issued in the previous cycle and its data is valid now.
  - Replace the target nibble with the latched colour.
  - Go to WR.
- WR: when disp_en=0, write the merged word with bram_we=4'hF, then go to IDLE. If disp_en=1, wait.
- Write latency:
  - Uncontended: accept at T, read at T+1, capture at T+2, write at T+3, wr_ready=1 at T+4.
  - Each display-contended cycle adds 1.
- FILL:
  - fill_busy=1.
  - Each cycle with disp_en=0: write {8{fill_color}} with we=4'hF at word=counter, counter+1.
  - After writing word FB_WORDS-1: go to IDLE; fill_busy=0 next cycle.
  - fill_start and wr_valid are ignored while in FILL (wr_ready=0).
- Hazards:
  - A display read of a word between its RD and WR returns pre-write data. This is acceptable.
  - No write coalescing.
- Reset mid-operation: aborts immediately to IDLE with no further BRAM writes. A partial fill is left as-is.
- Widths and wrap:
  - Pixel index is 19 bits.
  - Word index is p[18:3]; nibble index is p[2:0].
  - The fill counter is 16 bits and never wraps (terminates at FB_WORDS-1).

Decomposition:
- Package fb_pkg holds:
  - H_RES, V_RES, PIX_PER_WORD=8, FB_WORDS;
  - the state enum;
  - nibble insert/extract functions (nibble 0 = [31:28]).
- Sub-module fb_addr_calc: (x, y) → word byte address, nibble index, in_range.
  - Instantiated twice: display path and write path.

Test Plan:
- Reset held 3 cycles → bram_en=0, bram_we=0, wr_ready=0, fill_busy=0, disp_valid=0 throughout.
- BRAM model word0=0x12345678; write x=3, y=0, colour=0xC, disp_en=0 → read addr 0 at T+1; write addr 0x0, din=0x123C5678, we=0xF at T+3; wr_ready=1 at T+4.
- Same write with disp_en high T+1..T+5 → display reads only during T+1..T+5; RD read issued at T+6; write at T+8. disp_pixel matches the model nibble 1 cycle after each disp_en.
- fill_start with fill_color=0x9, disp_en=0 → 38400 consecutive writes of 0x99999999. Addresses run 0x0..0x257FC. fill_busy=1 for exactly 38400 cycles. A wr_valid during the fill is never accepted.
- Write x=640, y=5 → accepted (wr_ready=1), no BRAM access, wr_ready=1 again next cycle.
- Reset asserted after 100 fill words → no further writes. fill_busy=0 while in reset. Words 0..99 = fill value; word 100 is unchanged.
